// File: rtl/mod_counter_fsm.sv
// Up/down modulo counter with IDLE/RUN/DONE run control and a registered terminal-count pulse.
// Optional enable prescaler is compiled in when COUNTER_PRESCALE_EN is defined.
module mod_counter_fsm #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MAX_VAL = 255,
  parameter int unsigned PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               enable,
  input  logic               up_dn,
  input  logic               mode,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
`ifdef COUNTER_PRESCALE_EN
  input  logic [PRESC_W-1:0] presc_div,
`endif
  output logic [WIDTH-1:0]   count,
  output logic               busy,
  output logic               done,
  output logic               tc
);

  if ((64'(MAX_VAL) > ((64'd1 << WIDTH) - 64'd1)) || (PRESC_W == 0)) begin : g_bad_param
    $error("mod_counter_fsm: MAX_VAL exceeds WIDTH range or PRESC_W is zero");
  end

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] MaxV = WIDTH'(MAX_VAL);

  state_e           r_state, w_state_d;
  logic [WIDTH-1:0] r_count, w_count_d;
  logic             r_tc, w_tc_d;
  logic             w_tick;
  logic             w_term;

`ifdef COUNTER_PRESCALE_EN
  logic [PRESC_W-1:0] r_presc, w_presc_d;
  assign w_tick = (r_state == StRun) && enable && (r_presc == presc_div);
`else
  assign w_tick = (r_state == StRun) && enable;
`endif

  assign w_term = up_dn ? (r_count == MaxV) : (r_count == '0);

  always_comb begin
    w_state_d = r_state;
    w_count_d = r_count;
    w_tc_d    = 1'b0;
`ifdef COUNTER_PRESCALE_EN
    w_presc_d = r_presc;
`endif
    if (load) begin
      w_count_d = (load_val > MaxV) ? MaxV : load_val;
`ifdef COUNTER_PRESCALE_EN
      w_presc_d = '0;
`endif
    end else begin
      case (r_state)
        StIdle, StDone: begin
          if (stop) begin
            w_state_d = StIdle;
`ifdef COUNTER_PRESCALE_EN
            w_presc_d = '0;
`endif
          end else if (start) begin
            w_state_d = StRun;
            w_count_d = up_dn ? '0 : MaxV;
`ifdef COUNTER_PRESCALE_EN
            w_presc_d = '0;
`endif
          end
        end
        StRun: begin
          if (stop) begin
            w_state_d = StIdle;
`ifdef COUNTER_PRESCALE_EN
            w_presc_d = '0;
`endif
          end else if (w_tick) begin
`ifdef COUNTER_PRESCALE_EN
            w_presc_d = '0;
`endif
            if (!w_term) begin
              w_count_d = up_dn ? (r_count + WIDTH'(1)) : (r_count - WIDTH'(1));
            end else begin
              // Terminal step: wrap in continuous mode, park in DONE in one-shot mode.
              w_tc_d = 1'b1;
              if (mode) begin
                w_count_d = up_dn ? '0 : MaxV;
              end else begin
                w_state_d = StDone;
              end
            end
          end
`ifdef COUNTER_PRESCALE_EN
          else if (enable) begin
            w_presc_d = r_presc + PRESC_W'(1);
          end
`endif
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_count <= '0;
      r_tc    <= 1'b0;
`ifdef COUNTER_PRESCALE_EN
      r_presc <= '0;
`endif
    end else begin
      r_state <= w_state_d;
      r_count <= w_count_d;
      r_tc    <= w_tc_d;
`ifdef COUNTER_PRESCALE_EN
      r_presc <= w_presc_d;
`endif
    end
  end

  assign count = r_count;
  assign busy  = (r_state == StRun);
  assign done  = (r_state == StDone);
  assign tc    = r_tc;

endmodule
